// File: rtl/obi_data_responder_if.sv
// obi_data_responder_if: one core's data request/response bus as seen by its responder.
// Latency: none, it only groups wires; timing is set by the responder.
// Backpressure: the requester holds req and payload until data_gnt_o is returned.
interface obi_data_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  // Core side: drives the request, consumes grant and response.
  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  // Responder side: consumes the request, drives grant and response.
  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/obi_data_responder.sv
// obi_data_responder: data-side responder backing one core's req/gnt/rvalid port with a word memory.
// Latency: rvalid LATENCY cycles after the grant edge, in grant order; a write is visible to the next grant.
// Backpressure: grant withheld while gnt_stall_i is high or MAX_OUTSTANDING responses are in flight,
//               except that a response retiring this cycle frees its slot for a same-cycle grant.
module obi_data_responder #(
  parameter int DEPTH_WORDS     = 256,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obi_data_responder_if.slave bus,
  input  logic                gnt_stall_i,
  output logic [2:0]          outstanding_o,
  output logic [15:0]         resp_count_o
);
  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  // One response slot: the last slot of the shift register drives the bus outputs.
  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } stage_t;

  // Memory is deliberately left without reset so contents survive a reset.
  logic [31:0] r_mem [DEPTH_WORDS];
  stage_t      r_pipe [LATENCY];
  logic [2:0]  r_outstanding;
  logic [15:0] r_resp_count;

  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_gnt;
  logic          w_retire;
  logic [31:0]   w_rd_word;
  stage_t        w_stage0;
  logic [1:0]    w_unused_addr_lsb;

  // Word addressing: the byte offset is not part of the index.
  assign w_idx             = bus.data_addr_i[2 +: AW];
  assign w_unused_addr_lsb = bus.data_addr_i[1:0];
  // Any address bit above the index means the word lies beyond the array.
  assign w_oor             = |bus.data_addr_i[31:2+AW];

  assign w_retire  = r_pipe[LATENCY-1].vld;
  assign w_gnt     = bus.data_req_i && !gnt_stall_i &&
                     ((r_outstanding < MAX_OUT) || w_retire);
  assign w_rd_word = r_mem[w_idx];

  // Stage 0 payload: only in-range reads return data; writes and errors return zero.
  always_comb begin
    w_stage0       = '0;
    w_stage0.vld   = w_gnt;
    w_stage0.err   = w_gnt && w_oor;
    if (w_gnt && !bus.data_we_i && !w_oor) begin
      w_stage0.rdata = w_rd_word;
    end
  end

  // Byte-enabled write on the grant edge; out-of-range requests never touch memory.
  always_ff @(posedge clk_i) begin
    if (w_gnt && bus.data_we_i && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Fixed-latency response shift register; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Outstanding count: grant adds one, retire removes one, both together cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_retire})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Completed-response counter, free-running with natural 16-bit wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_count <= '0;
    end else if (w_retire) begin
      r_resp_count <= r_resp_count + 16'd1;
    end
  end

  assign bus.data_gnt_o    = w_gnt;
  assign bus.data_rvalid_o = r_pipe[LATENCY-1].vld;
  assign bus.data_err_o    = r_pipe[LATENCY-1].err;
  assign bus.data_rdata_o  = r_pipe[LATENCY-1].rdata;
  assign outstanding_o     = r_outstanding;
  assign resp_count_o      = r_resp_count;
endmodule

// File: tb/tb_obi_data_responder.sv
// tb_obi_data_responder: four responder configurations driven side by side against a queue-based model.
// Latency: the model predicts each response as due LATENCY sampled cycles after the cycle it was granted.
// Backpressure: the random requester holds its request stable until it sees the grant.
module tb_obi_data_responder;
  localparam int NC = 4;
  localparam int DEP  [NC] = '{256, 256, 256, 16};
  localparam int LAT  [NC] = '{1, 2, 2, 3};
  localparam int MAXO [NC] = '{2, 1, 2, 4};

  typedef struct {
    int          due;
    bit          err;
    bit          known;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0] req;
  logic [NC-1:0] we;
  logic [NC-1:0] stall;
  logic [3:0]    be    [NC];
  logic [31:0]   addr  [NC];
  logic [31:0]   wdata [NC];

  logic [NC-1:0] gnt_w;
  logic [NC-1:0] rvalid_w;
  logic [NC-1:0] err_w;
  logic [31:0]   rdata_w [NC];
  logic [2:0]    outs_w  [NC];
  logic [15:0]   rcnt_w  [NC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    obi_data_responder_if bus ();

    obi_data_responder #(
      .DEPTH_WORDS    (DEP[g]),
      .LATENCY        (LAT[g]),
      .MAX_OUTSTANDING(MAXO[g])
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .bus          (bus),
      .gnt_stall_i  (stall[g]),
      .outstanding_o(outs_w[g]),
      .resp_count_o (rcnt_w[g])
    );

    assign bus.data_req_i   = req[g];
    assign bus.data_we_i    = we[g];
    assign bus.data_be_i    = be[g];
    assign bus.data_addr_i  = addr[g];
    assign bus.data_wdata_i = wdata[g];
    assign gnt_w[g]         = bus.data_gnt_o;
    assign rvalid_w[g]      = bus.data_rvalid_o;
    assign err_w[g]         = bus.data_err_o;
    assign rdata_w[g]       = bus.data_rdata_o;

    resp_t       q[$];
    logic [31:0] mem [int];
    logic [15:0] m_cnt = '0;
    int          k = 0;

    // Model: pending responses are a queue tagged with their due cycle; outstanding is its length.
    always @(negedge clk) begin : model
      bit          exp_rv;
      bit          exp_gnt;
      bit          oor;
      int          idx;
      logic [31:0] w;
      resp_t       r;
      k++;
      if (!rst_n) begin
        q.delete();
        m_cnt = '0;
        chk($sformatf("c%0d reset rvalid", g), 32'(rvalid_w[g]), 32'd0);
        chk($sformatf("c%0d reset outstanding", g), 32'(outs_w[g]), 32'd0);
        chk($sformatf("c%0d reset resp_count", g), 32'(rcnt_w[g]), 32'd0);
      end else begin
        exp_rv  = (q.size() > 0) && (q[0].due == k);
        exp_gnt = req[g] && !stall[g] && ((q.size() < MAXO[g]) || exp_rv);
        chk($sformatf("c%0d cyc%0d gnt", g, k), 32'(gnt_w[g]), 32'(exp_gnt));
        chk($sformatf("c%0d cyc%0d rvalid", g, k), 32'(rvalid_w[g]), 32'(exp_rv));
        chk($sformatf("c%0d cyc%0d outstanding", g, k), 32'(outs_w[g]), 32'(q.size()));
        chk($sformatf("c%0d cyc%0d resp_count", g, k), 32'(rcnt_w[g]), 32'(m_cnt));
        if (exp_rv) begin
          chk($sformatf("c%0d cyc%0d err", g, k), 32'(err_w[g]), 32'(q[0].err));
          if (q[0].known) begin
            chk($sformatf("c%0d cyc%0d rdata", g, k), rdata_w[g], q[0].rdata);
          end
          void'(q.pop_front());
          m_cnt = m_cnt + 16'd1;
        end
        if (exp_gnt) begin
          oor     = ({2'b00, addr[g][31:2]} >= 32'(DEP[g]));
          idx     = int'(addr[g][31:2]);
          r.due   = k + LAT[g];
          r.err   = oor;
          r.known = oor || we[g] || mem.exists(idx);
          r.rdata = (oor || we[g] || !mem.exists(idx)) ? 32'd0 : mem[idx];
          q.push_back(r);
          if (!oor && we[g]) begin
            if (mem.exists(idx)) begin
              w = mem[idx];
              for (int b = 0; b < 4; b++) begin
                if (be[g][b]) w[8*b +: 8] = wdata[g][8*b +: 8];
              end
              mem[idx] = w;
            end else if (be[g] == 4'hf) begin
              mem[idx] = wdata[g];
            end
          end
        end
      end
    end
  end

  // Present one request and hold it until granted; returns just after the grant edge.
  task automatic issue(input int c, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    req[c] = 1'b1; we[c] = w; be[c] = b; addr[c] = a; wdata[c] = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = gnt_w[c];
    end
    chk($sformatf("c%0d grant within 50 cycles", c), 32'(got), 32'd1);
    @(posedge clk); #1;
    req[c] = 1'b0;
  endtask

  task automatic read_check(input int c, input logic [31:0] a, input logic [31:0] exp_d,
                            input bit exp_e, input string name);
    issue(c, 1'b0, 4'hf, a, 32'd0);
    repeat (LAT[c]) @(negedge clk);
    chk({name, " rvalid"}, 32'(rvalid_w[c]), 32'd1);
    chk({name, " rdata"}, rdata_w[c], exp_d);
    chk({name, " err"}, 32'(err_w[c]), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int c, input int ncyc);
    bit pend = 1'b0;
    int r;
    for (int i = 0; i < 8; i++) issue(c, 1'b1, 4'hf, 32'(i * 4), $urandom);
    for (int i = 0; i < ncyc; i++) begin
      if (!pend) begin
        if ($urandom_range(0, 9) < 7) begin
          r        = $urandom_range(0, 9);
          we[c]    = 1'($urandom_range(0, 1));
          be[c]    = 4'($urandom_range(0, 15));
          wdata[c] = $urandom;
          if (r < 8)       addr[c] = 32'(r * 4) | 32'($urandom_range(0, 3));
          else if (r == 8) addr[c] = 32'(DEP[c] * 4) + 32'($urandom_range(0, 15) * 4);
          else             addr[c] = 32'h8000_0000 | 32'($urandom_range(0, 255));
          req[c] = 1'b1;
          pend   = 1'b1;
        end else begin
          req[c] = 1'b0;
        end
      end
      stall[c] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (req[c] && gnt_w[c]) pend = 1'b0;
      @(posedge clk); #1;
    end
    req[c] = 1'b0;
    stall[c] = 1'b0;
    repeat (LAT[c] + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: still running at time 500000, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nrv;
    rst_n = 1'b1;
    req = '0; we = '0; stall = '0;
    for (int c = 0; c < NC; c++) begin
      be[c] = '0; addr[c] = '0; wdata[c] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Grant stays combinational during reset.
    req[0] = 1'b1;
    #1;
    chk("reset gnt follows req", 32'(gnt_w[0]), 32'd1);
    chk("reset rdata", rdata_w[0], 32'd0);
    chk("reset err", 32'(err_w[0]), 32'd0);
    req[0] = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;

    // Read-after-write, partial write, out-of-range, zero byte-enable (LATENCY=1).
    issue(0, 1'b1, 4'hf, 32'h10, 32'hDEADBEEF);
    read_check(0, 32'h10, 32'hDEADBEEF, 1'b0, "raw 0x10");
    issue(0, 1'b1, 4'hf, 32'h20, 32'h11223344);
    issue(0, 1'b1, 4'b0001, 32'h20, 32'h000000AA);
    read_check(0, 32'h20, 32'h112233AA, 1'b0, "byte0 write");
    issue(0, 1'b1, 4'hf, 32'h0, 32'h00000055);
    issue(0, 1'b1, 4'hf, 32'h400, 32'h00000066);
    read_check(0, 32'h400, 32'h0, 1'b1, "oor read 0x400");
    read_check(0, 32'h0, 32'h00000055, 1'b0, "no alias from oor write");
    read_check(0, 32'h8000_0010, 32'h0, 1'b1, "oor top bit");
    issue(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF);
    read_check(0, 32'h20, 32'h112233AA, 1'b0, "be0 write no-op");

    // LATENCY=2, MAX_OUTSTANDING=1: request held six cycles.
    nrv = 0;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hf; addr[1] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("held req gnt cycle %0d", i), 32'(gnt_w[1]), 32'((i % 2) == 0));
      nrv += int'(rvalid_w[1]);
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      nrv += int'(rvalid_w[1]);
    end
    chk("held req response count", 32'(nrv), 32'd3);
    @(posedge clk); #1;

    // LATENCY=2, MAX_OUTSTANDING=2: stall while two responses are in flight.
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hf; addr[2] = 32'h10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("stall prefill gnt %0d", i), 32'(gnt_w[2]), 32'd1);
      @(posedge clk); #1;
    end
    stall[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall gnt %0d", i), 32'(gnt_w[2]), 32'd0);
      chk($sformatf("stall rvalid %0d", i), 32'(rvalid_w[2]), 32'(i < 2));
      @(posedge clk); #1;
    end
    stall[2] = 1'b0; req[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset pulse with two responses pending.
    req[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("pre-reset gnt %0d", i), 32'(gnt_w[2]), 32'd1);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async reset rvalid", 32'(rvalid_w[2]), 32'd0);
    chk("async reset outstanding", 32'(outs_w[2]), 32'd0);
    chk("async reset resp_count", 32'(rcnt_w[2]), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset rvalid %0d", i), 32'(rvalid_w[2]), 32'd0);
      chk($sformatf("post-reset outstanding %0d", i), 32'(outs_w[2]), 32'd0);
    end
    chk("post-reset resp_count", 32'(rcnt_w[2]), 32'd0);
    @(posedge clk); #1;
    read_check(0, 32'h10, 32'hDEADBEEF, 1'b0, "memory kept across reset");

    // Randomized traffic on every configuration, checked by the model.
    for (int c = 0; c < NC; c++) rand_phase(c, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
